// File: rtl/pattern_scan_ctrl.sv
// Word-to-serial frame sequencer with a programmable PLEN-bit pattern matcher and a saturating hit counter.
// Define PSCAN_NONOVERLAP_EN for non-overlapping detection; by default matches may overlap.
module pattern_scan_ctrl #(
  parameter int              W       = 8,
  parameter int              PLEN    = 6,
  parameter int              CW      = 8,
  parameter logic [PLEN-1:0] DEF_PAT = 6'b101101
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [PLEN-1:0] cfg_pat,
  input  logic            start,
  input  logic            in_valid,
  input  logic [W-1:0]    in_data,
  input  logic            in_last,
  output logic            in_ready,
  output logic            bit_out,
  output logic            bit_valid,
  output logic            hit,
  output logic [CW-1:0]   hit_cnt,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam int              BW        = $clog2(W);
  localparam int              SW        = $clog2(PLEN);
  localparam logic [BW-1:0]   BIT_LAST  = BW'(W - 1);
  localparam logic [SW-1:0]   SEEN_FULL = SW'(PLEN - 1);

  state_t          state, state_nxt;
  logic [PLEN-1:0] pat;
  logic [W-1:0]    shift_q;
  logic            last_q;
  logic [BW-1:0]   bit_cnt;
  logic [PLEN-2:0] hist;
  logic [SW-1:0]   seen;
  logic [PLEN-1:0] window;
  logic            frame_clr;
  logic            word_ld;

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    bit_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    frame_clr = 1'b0;
    word_ld   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          frame_clr = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_ld   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        bit_valid = 1'b1;
        if (bit_cnt == BIT_LAST) state_nxt = last_q ? DONE : LOAD;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The window pairs the stored history with the bit on the wire, so hit lands on the completing bit.
  assign bit_out = bit_valid & shift_q[W-1];
  assign window  = {hist, bit_out};
  assign hit     = bit_valid && (seen == SEEN_FULL) && (window == pat);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat     <= DEF_PAT;
      shift_q <= '0;
      last_q  <= 1'b0;
      bit_cnt <= '0;
      hist    <= '0;
      seen    <= '0;
      hit_cnt <= '0;
    end else begin
      // cfg_we lands in the same edge as start, so the new pattern is live for the first bit.
      if (state == IDLE && cfg_we) pat <= cfg_pat;

      if (frame_clr) begin
        hist    <= '0;
        seen    <= '0;
        hit_cnt <= '0;
      end

      if (word_ld) begin
        shift_q <= in_data;
        last_q  <= in_last;
        bit_cnt <= '0;
      end

      if (bit_valid) begin
        shift_q <= {shift_q[W-2:0], 1'b0};
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        if (hit && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
`ifdef PSCAN_NONOVERLAP_EN
        if (hit) begin
          hist <= '0;
          seen <= '0;
        end else begin
          hist <= window[PLEN-2:0];
          if (seen != SEEN_FULL) seen <= seen + 1'b1;
        end
`else
        hist <= window[PLEN-2:0];
        if (seen != SEEN_FULL) seen <= seen + 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench for pattern_scan_ctrl: directed frames push expected bits/hits and counts,
// monitors pop and compare whenever the DUTs present a bit or a done pulse.
module tb_pattern_scan_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic b;
    logic h;
  } bit_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  // main instance: W=8, PLEN=6, CW=8
  logic       cfg_we = 1'b0;
  logic [5:0] cfg_pat = '0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       in_ready, bit_out, bit_valid, hit, busy, done;
  logic [7:0] hit_cnt;

  // saturation instance: PLEN=2, CW=2
  logic       cfg_we2 = 1'b0;
  logic [1:0] cfg_pat2 = '0;
  logic       start2 = 1'b0;
  logic       in_valid2 = 1'b0;
  logic [7:0] in_data2 = '0;
  logic       in_last2 = 1'b0;
  logic       in_ready2, bit_out2, bit_valid2, hit2, busy2, done2;
  logic [1:0] hit_cnt2;

  bit_exp_t q1[$];
  bit_exp_t q2[$];
  int       c1[$];
  int       c2[$];
  bit_exp_t e1, e2;

  pattern_scan_ctrl #(.W(8), .PLEN(6), .CW(8), .DEF_PAT(6'b101101)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .bit_out(bit_out), .bit_valid(bit_valid), .hit(hit), .hit_cnt(hit_cnt),
    .busy(busy), .done(done)
  );

  pattern_scan_ctrl #(.W(8), .PLEN(2), .CW(2), .DEF_PAT(2'b11)) dut2 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we2), .cfg_pat(cfg_pat2), .start(start2),
    .in_valid(in_valid2), .in_data(in_data2), .in_last(in_last2), .in_ready(in_ready2),
    .bit_out(bit_out2), .bit_valid(bit_valid2), .hit(hit2), .hit_cnt(hit_cnt2),
    .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitors: compare every presented bit and every done pulse against the queues.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bit_valid) begin
        if (q1.size() == 0) fail_event("dut_unexpected_bit");
        else begin
          e1 = q1.pop_front();
          check("dut_bit_out", bit_out, e1.b);
          check("dut_hit", hit, e1.h);
        end
      end else check("dut_hit_outside_shift", hit, 0);
      if (done) begin
        if (c1.size() == 0) fail_event("dut_unexpected_done");
        else check("dut_hit_cnt_at_done", hit_cnt, c1.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bit_valid2) begin
        if (q2.size() == 0) fail_event("sat_unexpected_bit");
        else begin
          e2 = q2.pop_front();
          check("sat_bit_out", bit_out2, e2.b);
          check("sat_hit", hit2, e2.h);
        end
      end
      if (done2) begin
        if (c2.size() == 0) fail_event("sat_unexpected_done");
        else check("sat_hit_cnt_at_done", hit_cnt2, c2.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mask bit i marks a hit on the bit serialized from d[i]
  task automatic push_word(input logic [7:0] d, input logic [7:0] m);
    for (int i = W - 1; i >= 0; i--) q1.push_back('{b: d[i], h: m[i]});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_bit_out"}, bit_out, 0);
    check({tag, "_bit_valid"}, bit_valid, 0);
    check({tag, "_hit"}, hit, 0);
    check({tag, "_hit_cnt"}, hit_cnt, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic start_frame(input logic we, input logic [5:0] p);
    start = 1'b1; cfg_we = we; cfg_pat = p;
    tick();
    start = 1'b0; cfg_we = 1'b0;
    check("start_busy", busy, 1);
    check("start_in_ready", in_ready, 1);
  endtask

  task automatic send_word(input logic [7:0] d, input logic l, output int acc);
    in_valid = 1'b1; in_data = d; in_last = l;
    for (int n = 0; n < 40 && !in_ready; n++) tick();
    if (!in_ready) fail_event("in_ready_timeout");
    tick();
    acc = cyc;
    in_valid = 1'b0; in_last = 1'b0;
    check("first_bit_latency", bit_valid, 1);
    check("in_ready_low_in_shift", in_ready, 0);
  endtask

  task automatic end_frame();
    repeat (W) @(posedge clk);
    #1;
    check("done_pulse", done, 1);
    check("busy_in_done", busy, 1);
    check("no_bit_in_done", bit_valid, 0);
    tick();
    check("done_single_cycle", done, 0);
    check("busy_low_after_done", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0, a1, a2;

    // reset state, during and after reset
    #1 check_all_zero("in_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();
    check_all_zero("after_reset");

    // single word with default pattern; cfg_we during the frame must be ignored
    push_word(8'b10110101, 8'b00000100);
    c1.push_back(1);
    start_frame(1'b0, 6'b000000);
    cfg_we = 1'b1; cfg_pat = 6'b111000;
    send_word(8'b10110101, 1'b1, a0);
    cfg_we = 1'b0;
    end_frame();

    // two words, 5-cycle stall between them, start ignored while busy
    push_word(8'b10110110, 8'b00000100);
`ifdef PSCAN_NONOVERLAP_EN
    push_word(8'b10000000, 8'b00000000);
    c1.push_back(1);
`else
    push_word(8'b10000000, 8'b10000000);
    c1.push_back(2);
`endif
    start_frame(1'b0, 6'b000000);
    send_word(8'b10110110, 1'b0, a0);
    repeat (W) tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_in_ready", in_ready, 1);
      check("stall_bit_valid", bit_valid, 0);
      start = (i == 2);
      tick();
    end
    start = 1'b0;
    send_word(8'b10000000, 1'b1, a0);
    end_frame();

    // pattern write coincident with start, then three back-to-back words
    push_word(8'b11100011, 8'b00000100);
    push_word(8'b10001110, 8'b00010000);
    push_word(8'b00000000, 8'b01000000);
    c1.push_back(3);
    start_frame(1'b1, 6'b111000);
    send_word(8'b11100011, 1'b0, a0);
    send_word(8'b10001110, 1'b0, a1);
    send_word(8'b00000000, 1'b1, a2);
    check("throughput_word2", a1 - a0, W + 1);
    check("throughput_word3", a2 - a1, W + 1);
    end_frame();
    repeat (3) tick();
    check("hit_cnt_held_in_idle", hit_cnt, 3);

    // reset during the 4th shift cycle
    q1.push_back('{b: 1'b1, h: 1'b0});
    q1.push_back('{b: 1'b1, h: 1'b0});
    q1.push_back('{b: 1'b1, h: 1'b0});
    start_frame(1'b0, 6'b000000);
    send_word(8'b11111111, 1'b0, a0);
    repeat (3) tick();
    check("pre_abort_bit_valid", bit_valid, 1);
    rst = 1'b0;
    #1 check_all_zero("mid_frame_reset");
    tick();
    rst = 1'b1;
    tick();

    // fresh frame after abort: default pattern restored, no stale history
    push_word(8'b10110101, 8'b00000100);
    c1.push_back(1);
    start_frame(1'b0, 6'b000000);
    send_word(8'b10110101, 1'b1, a0);
    end_frame();

    // saturation on the PLEN=2, CW=2 instance
    for (int i = W - 1; i >= 0; i--) begin
`ifdef PSCAN_NONOVERLAP_EN
      q2.push_back('{b: 1'b1, h: (i % 2 == 0)});
`else
      q2.push_back('{b: 1'b1, h: (i != W - 1)});
`endif
    end
    c2.push_back(3);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("sat_in_ready", in_ready2, 1);
    in_valid2 = 1'b1; in_data2 = 8'hFF; in_last2 = 1'b1;
    tick();
    in_valid2 = 1'b0; in_last2 = 1'b0;
    repeat (W) @(posedge clk);
    #1;
    check("sat_done", done2, 1);
    tick();
    check("sat_busy_low", busy2, 0);
    check("sat_hit_cnt_held", hit_cnt2, 3);

    tick();
    check("dut_queue_drained", q1.size(), 0);
    check("dut_cnt_queue_drained", c1.size(), 0);
    check("sat_queue_drained", q2.size(), 0);
    check("sat_cnt_queue_drained", c2.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
